// File: rtl/bp_pkg.sv
// ============================================================================
// bp_pkg: shared types and defaults for the branch-resolution controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bp_pkg;

    localparam int BP_GHR_BITS      = 8;
    localparam int BP_DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [31:0]            pc;
        logic                   taken;
        logic [BP_GHR_BITS-1:0] ghr;
    } bp_entry_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bp_state_e;

endpackage

`default_nettype wire

// File: rtl/bp_sat_counter.sv
// ============================================================================
// bp_sat_counter: up-counter that sticks at all-ones instead of wrapping.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bp_sat_counter #(
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                inc_i,
    output logic [CNT_BITS-1:0] count_o
);

    logic [CNT_BITS-1:0] count_q;
    logic [CNT_BITS-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/bp_resolve_ctrl.sv
// ============================================================================
// bp_resolve_ctrl: in-order tracker of in-flight branch predictions; drives
// predictor updates, mispredict recovery and hit/miss statistics.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bp_resolve_ctrl
    import bp_pkg::*;
#(
    parameter int DEPTH        = BP_DEFAULT_DEPTH,
    parameter int GHR_BITS     = BP_GHR_BITS,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_BITS     = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pred_valid_i,
    input  logic [31:0]         pred_pc_i,
    input  logic                pred_taken_i,
    input  logic [GHR_BITS-1:0] pred_ghr_i,
    output logic                pred_ready_o,
    input  logic                res_valid_i,
    input  logic                res_taken_i,
    output logic                upd_valid_o,
    output logic [31:0]         upd_pc_o,
    output logic                upd_taken_o,
    output logic [GHR_BITS-1:0] upd_ghr_o,
    output logic                mispredict_o,
    output logic [GHR_BITS-1:0] restore_ghr_o,
    output logic [CNT_BITS-1:0] hit_cnt_o,
    output logic [CNT_BITS-1:0] miss_cnt_o,
    output logic                underflow_err_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int FCW = $clog2(FLUSH_CYCLES) + 1;

    logic [31:0]         pc_mem    [DEPTH];
    logic                taken_mem [DEPTH];
    logic [GHR_BITS-1:0] ghr_mem   [DEPTH];

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    bp_state_e      state_q, state_d;
    logic [FCW-1:0] flush_cnt_q, flush_cnt_d;

    logic                upd_valid_q, upd_taken_q, mispredict_q, underflow_q;
    logic [31:0]         upd_pc_q;
    logic [GHR_BITS-1:0] upd_ghr_q, restore_ghr_q;

    logic full, empty, push, pop, miss;
    logic [AW-1:0] rd_idx, wr_idx;

    assign rd_idx = rd_ptr_q[AW-1:0];
    assign wr_idx = wr_ptr_q[AW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign push   = pred_valid_i && pred_ready_o;
    assign pop    = res_valid_i && !empty;
    assign miss   = pop && (res_taken_i != taken_mem[rd_idx]);

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        pred_ready_o = (state_q == RUN) && !full;
        case (state_q)
            RUN: begin
                if (miss) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FCW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // A mispredict discards every younger entry, including one pushed this cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (miss) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !miss) begin
            pc_mem[wr_idx]    <= pred_pc_i;
            taken_mem[wr_idx] <= pred_taken_i;
            ghr_mem[wr_idx]   <= pred_ghr_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_taken_q   <= 1'b0;
            upd_ghr_q     <= '0;
            mispredict_q  <= 1'b0;
            restore_ghr_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            upd_valid_q  <= pop;
            mispredict_q <= miss;
            if (pop) begin
                upd_pc_q    <= pc_mem[rd_idx];
                upd_taken_q <= res_taken_i;
                upd_ghr_q   <= ghr_mem[rd_idx];
            end
            if (miss) begin
                restore_ghr_q <= {ghr_mem[rd_idx][GHR_BITS-2:0], res_taken_i};
            end
            if (res_valid_i && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    bp_sat_counter #(.CNT_BITS(CNT_BITS)) u_hit_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (pop && !miss),
        .count_o (hit_cnt_o)
    );

    bp_sat_counter #(.CNT_BITS(CNT_BITS)) u_miss_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (miss),
        .count_o (miss_cnt_o)
    );

    assign upd_valid_o     = upd_valid_q;
    assign upd_pc_o        = upd_pc_q;
    assign upd_taken_o     = upd_taken_q;
    assign upd_ghr_o       = upd_ghr_q;
    assign mispredict_o    = mispredict_q;
    assign restore_ghr_o   = restore_ghr_q;
    assign underflow_err_o = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_bp_resolve_ctrl.sv
// ============================================================================
// tb_bp_resolve_ctrl: directed self-checking bench for bp_resolve_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bp_resolve_ctrl;

    localparam int CNT_BITS = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pred_valid, pred_taken, pred_ready;
    logic [31:0] pred_pc;
    logic [7:0]  pred_ghr;
    logic        res_valid, res_taken;
    logic        upd_valid, upd_taken, mispredict, underflow_err;
    logic [31:0] upd_pc;
    logic [7:0]  upd_ghr, restore_ghr;
    logic [CNT_BITS-1:0] hit_cnt, miss_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bp_resolve_ctrl #(
        .DEPTH(4), .GHR_BITS(8), .FLUSH_CYCLES(2), .CNT_BITS(CNT_BITS)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pred_valid_i    (pred_valid),
        .pred_pc_i       (pred_pc),
        .pred_taken_i    (pred_taken),
        .pred_ghr_i      (pred_ghr),
        .pred_ready_o    (pred_ready),
        .res_valid_i     (res_valid),
        .res_taken_i     (res_taken),
        .upd_valid_o     (upd_valid),
        .upd_pc_o        (upd_pc),
        .upd_taken_o     (upd_taken),
        .upd_ghr_o       (upd_ghr),
        .mispredict_o    (mispredict),
        .restore_ghr_o   (restore_ghr),
        .hit_cnt_o       (hit_cnt),
        .miss_cnt_o      (miss_cnt),
        .underflow_err_o (underflow_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic tk, input logic [7:0] g);
        pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_ghr = g;
        tick();
        pred_valid = 1'b0;
    endtask

    task automatic resolve(input logic tk);
        res_valid = 1'b1; res_taken = tk;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ready"},     {31'd0, pred_ready},    32'd1);
        chk({tag, ".upd_valid"}, {31'd0, upd_valid},     32'd0);
        chk({tag, ".upd_pc"},    upd_pc,                 32'd0);
        chk({tag, ".upd_ghr"},   {24'd0, upd_ghr},       32'd0);
        chk({tag, ".mispred"},   {31'd0, mispredict},    32'd0);
        chk({tag, ".restore"},   {24'd0, restore_ghr},   32'd0);
        chk({tag, ".hit"},       {28'd0, hit_cnt},       32'd0);
        chk({tag, ".miss"},      {28'd0, miss_cnt},      32'd0);
        chk({tag, ".uflow"},     {31'd0, underflow_err}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_ghr = '0;
        res_valid = 1'b0; res_taken = 1'b0;
        #1;
        chk_reset_vals("rst");
        #20;
        reset_n = 1'b1;
        tick();

        // Single correct prediction
        push(32'h100, 1'b1, 8'h5A);
        resolve(1'b1);
        chk("t1.upd_valid", {31'd0, upd_valid},  32'd1);
        chk("t1.upd_pc",    upd_pc,              32'h100);
        chk("t1.upd_taken", {31'd0, upd_taken},  32'd1);
        chk("t1.upd_ghr",   {24'd0, upd_ghr},    32'h5A);
        chk("t1.mispred",   {31'd0, mispredict}, 32'd0);
        chk("t1.hit",       {28'd0, hit_cnt},    32'd1);
        tick();
        chk("t1.upd_pulse", {31'd0, upd_valid},  32'd0);

        // Mispredict flushes younger entry and stalls for two cycles
        push(32'h200, 1'b1, 8'h81);
        push(32'h204, 1'b0, 8'h03);
        resolve(1'b0);
        chk("t2.mispred",   {31'd0, mispredict},  32'd1);
        chk("t2.restore",   {24'd0, restore_ghr}, 32'h02);
        chk("t2.miss",      {28'd0, miss_cnt},    32'd1);
        chk("t2.upd_pc",    upd_pc,               32'h200);
        chk("t2.upd_taken", {31'd0, upd_taken},   32'd0);
        chk("t2.upd_ghr",   {24'd0, upd_ghr},     32'h81);
        chk("t2.ready_c1",  {31'd0, pred_ready},  32'd0);
        tick();
        chk("t2.ready_c2",  {31'd0, pred_ready},  32'd0);
        chk("t2.mp_pulse",  {31'd0, mispredict},  32'd0);
        tick();
        chk("t2.ready_c3",  {31'd0, pred_ready},  32'd1);

        // Queue is empty after the flush: resolve underflows
        resolve(1'b1);
        chk("t5.upd_valid", {31'd0, upd_valid},     32'd0);
        chk("t5.uflow",     {31'd0, underflow_err}, 32'd1);
        chk("t5.hit",       {28'd0, hit_cnt},       32'd1);

        // Fill to full, ignored fifth push, in-order retire with wrap-around
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) push(32'h10 + 32'(4 * k), 1'b1, 8'(r));
            chk("t3.full_ready", {31'd0, pred_ready}, 32'd0);
            push(32'h20, 1'b1, 8'hEE);
            for (int k = 0; k < 4; k++) begin
                resolve(1'b1);
                chk("t3.order_pc",  upd_pc,           32'h10 + 32'(4 * k));
                chk("t3.order_ghr", {24'd0, upd_ghr}, 32'(r));
            end
            resolve(1'b1);
            chk("t3.drained", {31'd0, upd_valid}, 32'd0);
        end
        chk("t3.hit",   {28'd0, hit_cnt},       32'd13);
        chk("t3.uflow", {31'd0, underflow_err}, 32'd1);

        // Simultaneous push and correct resolve
        push(32'h300, 1'b1, 8'h01);
        push(32'h304, 1'b1, 8'h02);
        pred_valid = 1'b1; pred_pc = 32'h308; pred_taken = 1'b1; pred_ghr = 8'h03;
        res_valid = 1'b1; res_taken = 1'b1;
        tick();
        pred_valid = 1'b0; res_valid = 1'b0;
        chk("t4.pop0", upd_pc, 32'h300);
        resolve(1'b1);
        chk("t4.pop1", upd_pc, 32'h304);
        resolve(1'b1);
        chk("t4.pop2", upd_pc, 32'h308);
        resolve(1'b1);
        chk("t4.empty", {31'd0, upd_valid}, 32'd0);
        chk("t4.hit_sat", {28'd0, hit_cnt},  32'hF);
        chk("t4.miss",    {28'd0, miss_cnt}, 32'd1);

        // Further hits keep the counter pinned at all-ones
        for (int k = 0; k < 5; k++) begin
            push(32'h400, 1'b0, 8'h00);
            resolve(1'b0);
        end
        chk("t7.hit_sat", {28'd0, hit_cnt}, 32'hF);

        // Reset mid-FLUSH with counters at 3/1
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            push(32'h40, 1'b1, 8'h11);
            resolve(1'b1);
        end
        push(32'h50, 1'b0, 8'h33);
        push(32'h54, 1'b0, 8'h44);
        resolve(1'b1);
        chk("t6.hit",     {28'd0, hit_cnt},     32'd3);
        chk("t6.miss",    {28'd0, miss_cnt},    32'd1);
        chk("t6.restore", {24'd0, restore_ghr}, 32'h67);
        chk("t6.ready",   {31'd0, pred_ready},  32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("t6.async");
        #1;
        reset_n = 1'b1;
        tick();
        chk("t6.ready_after", {31'd0, pred_ready}, 32'd1);
        push(32'h60, 1'b1, 8'h22);
        resolve(1'b1);
        chk("t6.post_pc",  upd_pc,            32'h60);
        chk("t6.post_hit", {28'd0, hit_cnt},  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bp_resolve_ctrl.md
Name: bp_resolve_ctrl

Overview:
- Tracks in-flight conditional-branch predictions from fetch and retires them in order when EX resolves them.
- Drives the update port of the gshare branch predictor.
- On a mispredict, flushes all younger predictions, returns a corrected global-history value, and stalls new predictions during pipeline refill.
- Sits between IF (predict), EX (resolve) and the predictor's update/GHR interface; also keeps hit and miss statistics.

Parameters:
- DEPTH, 4: in-flight prediction slots; power of 2, at least 2.
- GHR_BITS, 8: width of the global history snapshot.
- FLUSH_CYCLES, 2: cycles pred_ready is held low after a mispredict; at least 1.
- CNT_BITS, 16: width of the statistics counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- pred_valid  in  1  IF pushes a predicted branch
- pred_pc  in  32  PC of the branch
- pred_taken  in  1  predicted direction
- pred_ghr  in  GHR_BITS  GHR value used for the prediction
- pred_ready  out  1  slot available and not in flush
- res_valid  in  1  EX resolves the oldest branch
- res_taken  in  1  actual direction
- upd_valid  out  1  one-cycle update strobe to the predictor
- upd_pc  out  32  PC for the predictor update
- upd_taken  out  1  actual direction
- upd_ghr  out  GHR_BITS  snapshot GHR for indexing the update
- mispredict  out  1  one-cycle pulse
- restore_ghr  out  GHR_BITS  equals {snapshot[GHR_BITS-2:0], res_taken}; valid with mispredict
- hit_cnt  out  CNT_BITS  correct predictions, saturating
- miss_cnt  out  CNT_BITS  mispredicts, saturating
- underflow_err  out  1  sticky: res_valid seen while the queue was empty

Behaviour:
- Storage: circular FIFO of {pc, taken, ghr}.
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide.
  - full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- FSM states: RUN, FLUSH.
  - RUN -> FLUSH on an accepted resolve with a mismatch; flush counter loads FLUSH_CYCLES-1.
  - FLUSH decrements each cycle and returns to RUN when the counter is 0 at the clock edge.
  - A resolve cannot arrive in FLUSH because the queue is empty; if one does, it counts as underflow.
- pred_ready = (state==RUN) && !full. It is combinational and does not anticipate a same-cycle pop.
- Push: on pred_valid && pred_ready at the clock edge. pred_valid while not ready is ignored (no error).
- Resolve, accepted when res_valid && !empty:
  - Pop the head and compare res_taken with the stored taken.
  - Next cycle (registered, latency 1): upd_valid=1 with upd_pc, upd_taken=res_taken and upd_ghr taken from the entry.
  - On a hit: hit_cnt increments.
  - On a miss: mispredict=1, restore_ghr as defined above, miss_cnt increments.
  - On a miss, at the same edge: both pointers reset to 0 (all younger entries discarded) and any same-cycle push is dropped.
- Simultaneous push and correct resolve: both take effect. A push into a full queue is still blocked that cycle.
- res_valid while empty: no pop, no upd_valid, underflow_err set to 1 and held until reset.
- Counters saturate at all-ones and never wrap.
- upd_valid and mispredict are single-cycle pulses and are 0 in every other cycle.
- Reset (asynchronous, any time, including mid-FLUSH):
  - Pointers 0, state RUN, flush counter 0, pred_ready=1.
  - upd_valid=0, upd_pc=0, upd_taken=0, upd_ghr=0.
  - mispredict=0, restore_ghr=0.
  - hit_cnt=0, miss_cnt=0, underflow_err=0.
  - FIFO storage is not reset.

Decomposition:
- Package bp_pkg:
  - typedef bp_entry_t {logic [31:0] pc; logic taken; logic [GHR_BITS-1:0] ghr;} with GHR_BITS fixed to the predictor default of 8.
  - enum bp_state_e {RUN, FLUSH}.
  - localparam default depth.
- One sub-module: bp_sat_counter (CNT_BITS, inc → saturating count), instantiated for hit and miss.

Test Plan:
- Push pc=0x100 taken=1 ghr=0x5A, then resolve taken=1 → next cycle upd_valid=1, upd_pc=0x100, upd_ghr=0x5A, mispredict=0; hit_cnt=1.
- Push pc=0x200 taken=1 ghr=0x81 and pc=0x204, then resolve taken=0 → mispredict=1, restore_ghr=0x02, miss_cnt=1; queue empty; pred_ready low for exactly 2 cycles, then 1.
- Push 4 entries → pred_ready=0. Fifth pred_valid ignored. Four resolves return pcs in order 0x10, 0x14, 0x18, 0x1C, with pointer wrap-around exercised by repeating the sequence 3 times.
- Queue holds 2 entries; same cycle pred_valid plus a correct resolve → count stays 2; the new entry is retired last.
- res_valid with an empty queue → no upd_valid, underflow_err=1 and stays 1; a later normal push/resolve still works.
- Assert reset_n low mid-FLUSH with 0 entries and counters at 3/1 → all outputs return to their reset values asynchronously; pred_ready=1 after release.
- Force hit_cnt to saturate (CNT_BITS=4, 20 hits) → hit_cnt holds 0xF.
